// File: rtl/clic_arbiter.sv
// CLIC arbitration engine: scans the per-source register file, picks the highest-ctl pending source,
// gates it against the threshold and runs the claim handshake. Optional `CLIC_VECTOR_EN adds vector addressing.
module clic_arbiter #(
    parameter int clic_sources = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    scan_en,
    output logic [clic_sources-1:0] arb_idx,
    input  logic [7:0]              arb_ip,
    input  logic [7:0]              arb_ie,
    input  logic [7:0]              arb_attr,
    input  logic [7:0]              arb_ctl,
    input  logic [7:0]              thresh,
    input  logic                    claim_valid,
    output logic                    claim_ready,
    output logic [clic_sources-1:0] claim_id,
    output logic                    clr_valid,
    output logic [clic_sources-1:0] clr_idx,
    output logic                    clic_meip,
    output logic [clic_sources-1:0] clic_id,
    output logic [7:0]              clic_level,
    input  logic [31:0]             vtbase,
    output logic [31:0]             clic_vec_addr
);

    localparam logic [clic_sources-1:0] LAST_IDX = '1;
    localparam logic [clic_sources-1:0] IDX_ONE  = {{(clic_sources-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {SCAN, DRAIN, COMMIT, ACK} state_t;

    state_t                  state;
    logic                    rd_valid;
    logic [clic_sources-1:0] rd_idx;
    logic                    hold_valid;
    logic                    hold_cand;
    logic [7:0]              hold_ctl;
    logic [1:0]              hold_attr;
    logic                    best_valid;
    logic [clic_sources-1:0] best_idx;
    logic [7:0]              best_ctl;
    logic [1:0]              best_attr;
    logic                    win_edge;

    logic                    ev_cand;
    logic [7:0]              ev_ctl;
    logic [1:0]              ev_attr;
    logic                    take;
    logic                    publish;

    // A read dropped by a scan_en freeze is parked in the hold registers and evaluated on resume,
    // so the scan order (and the lower-index tie rule) is preserved without re-reading.
    always_comb begin
        ev_cand = hold_valid ? hold_cand : (arb_ip[0] & arb_ie[0]);
        ev_ctl  = hold_valid ? hold_ctl  : arb_ctl;
        ev_attr = hold_valid ? hold_attr : arb_attr[1:0];
        take    = (state == SCAN || state == DRAIN) && scan_en && (rd_valid || hold_valid)
                  && ev_cand && (!best_valid || ev_ctl > best_ctl);
        publish = best_valid && (best_ctl > thresh);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SCAN;
            arb_idx     <= '0;
            rd_valid    <= 1'b0;
            rd_idx      <= '0;
            hold_valid  <= 1'b0;
            hold_cand   <= 1'b0;
            hold_ctl    <= '0;
            hold_attr   <= '0;
            best_valid  <= 1'b0;
            best_idx    <= '0;
            best_ctl    <= '0;
            best_attr   <= '0;
            win_edge    <= 1'b0;
            claim_ready <= 1'b0;
            claim_id    <= '0;
            clr_valid   <= 1'b0;
            clr_idx     <= '0;
            clic_meip   <= 1'b0;
            clic_id     <= '0;
            clic_level  <= '0;
`ifdef CLIC_VECTOR_EN
            clic_vec_addr <= '0;
`endif
        end else begin
            claim_ready <= 1'b0;
            clr_valid   <= 1'b0;
            if (take) begin
                best_valid <= 1'b1;
                best_idx   <= rd_idx;
                best_ctl   <= ev_ctl;
                best_attr  <= ev_attr;
            end
            if (claim_valid && clic_meip && state != ACK) begin
                state       <= ACK;
                claim_ready <= 1'b1;
                claim_id    <= clic_id;
                clic_meip   <= 1'b0;
                clr_valid   <= win_edge;
                clr_idx     <= clic_id;
            end else begin
                case (state)
                    SCAN, DRAIN: begin
                        if (scan_en) begin
                            hold_valid <= 1'b0;
                            if (state == SCAN) begin
                                rd_valid <= 1'b1;
                                rd_idx   <= arb_idx;
                                arb_idx  <= arb_idx + IDX_ONE;
                                if (arb_idx == LAST_IDX) state <= DRAIN;
                            end else begin
                                rd_valid <= 1'b0;
                                state    <= COMMIT;
                            end
                        end else if (rd_valid) begin
                            rd_valid   <= 1'b0;
                            hold_valid <= 1'b1;
                            hold_cand  <= arb_ip[0] & arb_ie[0];
                            hold_ctl   <= arb_ctl;
                            hold_attr  <= arb_attr[1:0];
                        end
                    end
                    COMMIT: begin
                        clic_meip <= publish;
                        if (publish) begin
                            clic_id    <= best_idx;
                            clic_level <= best_ctl;
                            win_edge   <= best_attr[1];
                        end
`ifdef CLIC_VECTOR_EN
                        clic_vec_addr <= (publish && best_attr[0]) ? vtbase + 32'({best_idx, 2'b00}) : vtbase;
`endif
                        best_valid <= 1'b0;
                        arb_idx    <= '0;
                        state      <= SCAN;
                    end
                    default: begin
                        best_valid <= 1'b0;
                        rd_valid   <= 1'b0;
                        hold_valid <= 1'b0;
                        arb_idx    <= '0;
                        state      <= SCAN;
                    end
                endcase
            end
        end
    end

    logic unused_bits;
`ifdef CLIC_VECTOR_EN
    assign unused_bits = ^{arb_ip[7:1], arb_ie[7:1], arb_attr[7:2]};
`else
    assign clic_vec_addr = '0;
    assign unused_bits   = ^{arb_ip[7:1], arb_ie[7:1], arb_attr[7:2], vtbase, best_attr[0]};
`endif

endmodule
